// File: rtl/cpu_mem_req_master.sv
// Host-side initiator for the cpuMem port: turns single valid/ready register accesses into
// level-held cpuMemReq transactions, waits for the ack pulse and returns data or a timeout.
module cpu_mem_req_master #(
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter int unsigned           DATA_WIDTH   = 16,
  parameter int unsigned           TIMEOUT      = 64,
  parameter int unsigned           GAP_CYCLES   = 2,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clockCore,
  input  logic                  resetCore,
  input  logic                  hostReqVld,
  output logic                  hostReqRdy,
  input  logic                  hostReqRd,
  input  logic [ADDR_WIDTH-1:0] hostReqAddr,
  input  logic [DATA_WIDTH-1:0] hostReqWrData,
  output logic                  hostRspVld,
  output logic                  hostRspErr,
  output logic [DATA_WIDTH-1:0] hostRspRdData,
  output logic                  cpuMemReq,
  output logic                  cpuMemRd,
  output logic [ADDR_WIDTH-1:0] cpuMemAddr,
  output logic [DATA_WIDTH-1:0] cpuMemWrData,
  input  logic                  cpuMemAck,
  input  logic [DATA_WIDTH-1:0] cpuMemRdData,
  output logic [7:0]            timeoutCnt
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGap,
    StDrain
  } state_e;

  localparam int unsigned     GapW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [15:0]     TimerLast = 16'(TIMEOUT - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(GAP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [15:0]           timer_q, timer_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic                  req_q, req_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [7:0]            to_cnt_q, to_cnt_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    req_d      = req_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    rsp_vld_d  = 1'b0;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    to_cnt_d   = to_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (hostReqVld) begin
          rd_d      = hostReqRd;
          addr_d    = hostReqAddr;
          wr_data_d = hostReqWrData;
          req_d     = 1'b1;
          timer_d   = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        timer_d = timer_q + 16'd1;
        // An ack arriving in the timeout cycle still completes the access normally.
        if (cpuMemAck) begin
          req_d      = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_err_d  = 1'b0;
          rsp_data_d = rd_q ? cpuMemRdData : '0;
          gap_d      = '0;
          state_d    = StGap;
        end else if (timer_q == TimerLast) begin
          req_d      = 1'b0;
          rsp_vld_d  = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_data_d = TIMEOUT_DATA;
          to_cnt_d   = (to_cnt_q == 8'hff) ? to_cnt_q : to_cnt_q + 8'd1;
          timer_d    = '0;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        // The controller may still complete the abandoned access; its ack is swallowed here.
        timer_d = timer_q + 16'd1;
        if (cpuMemAck || (timer_q == TimerLast)) begin
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      gap_q      <= '0;
      req_q      <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      req_q      <= req_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign hostReqRdy    = (state_q == StIdle);
  assign hostRspVld    = rsp_vld_q;
  assign hostRspErr    = rsp_err_q;
  assign hostRspRdData = rsp_data_q;
  assign cpuMemReq     = req_q;
  assign cpuMemRd      = rd_q;
  assign cpuMemAddr    = addr_q;
  assign cpuMemWrData  = wr_data_q;
  assign timeoutCnt    = to_cnt_q;

endmodule

// File: tb/tb_cpu_mem_req_master.sv
// Directed bench for cpu_mem_req_master: cycle-exact host/controller sequences, with a
// scoreboard of expected host responses checked whenever hostRspVld fires.
module tb_cpu_mem_req_master;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clockCore = 1'b0;
  logic          resetCore = 1'b0;
  logic          hostReqVld = 1'b0;
  logic          hostReqRdy;
  logic          hostReqRd = 1'b0;
  logic [AW-1:0] hostReqAddr = '0;
  logic [DW-1:0] hostReqWrData = '0;
  logic          hostRspVld;
  logic          hostRspErr;
  logic [DW-1:0] hostRspRdData;
  logic          cpuMemReq;
  logic          cpuMemRd;
  logic [AW-1:0] cpuMemAddr;
  logic [DW-1:0] cpuMemWrData;
  logic          cpuMemAck = 1'b0;
  logic [DW-1:0] cpuMemRdData = '0;
  logic [7:0]    timeoutCnt;

  int checks = 0;
  int failures = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] ctrl_mem[256];

  cpu_mem_req_master #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT     (64),
    .GAP_CYCLES  (2),
    .TIMEOUT_DATA(16'hFFFF)
  ) dut (
    .clockCore    (clockCore),
    .resetCore    (resetCore),
    .hostReqVld   (hostReqVld),
    .hostReqRdy   (hostReqRdy),
    .hostReqRd    (hostReqRd),
    .hostReqAddr  (hostReqAddr),
    .hostReqWrData(hostReqWrData),
    .hostRspVld   (hostRspVld),
    .hostRspErr   (hostRspErr),
    .hostRspRdData(hostRspRdData),
    .cpuMemReq    (cpuMemReq),
    .cpuMemRd     (cpuMemRd),
    .cpuMemAddr   (cpuMemAddr),
    .cpuMemWrData (cpuMemWrData),
    .cpuMemAck    (cpuMemAck),
    .cpuMemRdData (cpuMemRdData),
    .timeoutCnt   (timeoutCnt)
  );

  always #5 clockCore = ~clockCore;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: every hostRspVld must match the oldest outstanding expectation.
  always @(negedge clockCore) begin
    if (hostRspVld) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL rsp_spurious: observed=1 expected=0");
      end
      if (exp_q.size() != 0) begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({hostRspErr, hostRspRdData} === e) else begin
          failures++;
          $error("FAIL rsp_data: observed=%0h expected=%0h", {hostRspErr, hostRspRdData}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clockCore);
    #1;
  endtask

  // Controller model: completes whatever is on the bus this cycle.
  task automatic ack_now();
    cpuMemAck    = 1'b1;
    cpuMemRdData = ctrl_mem[cpuMemAddr];
    if (!cpuMemRd) ctrl_mem[cpuMemAddr] = cpuMemWrData;
    tick();
    cpuMemAck    = 1'b0;
    cpuMemRdData = '0;
  endtask

  // Presents one host access in the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic push, input logic [DW:0] exp);
    chk("issue_rdy", 32'(hostReqRdy), 32'd1);
    hostReqVld    = 1'b1;
    hostReqRd     = rd;
    hostReqAddr   = addr;
    hostReqWrData = wd;
    if (push) exp_q.push_back(exp);
    tick();
    hostReqVld    = 1'b0;
    hostReqWrData = '0;
    chk("req_rise", 32'(cpuMemReq), 32'd1);
    chk("req_addr", 32'(cpuMemAddr), 32'(addr));
    chk("req_rd", 32'(cpuMemRd), 32'(rd));
    if (!rd) chk("req_wdata", 32'(cpuMemWrData), 32'(wd));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!hostReqRdy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(hostReqRdy), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ctrl_mem[i] = 16'(i * 3);

    // Reset values
    tick();
    chk("rst_rdy", 32'(hostReqRdy), 32'd1);
    chk("rst_req", 32'(cpuMemReq), 32'd0);
    chk("rst_rspvld", 32'(hostRspVld), 32'd0);
    chk("rst_tocnt", 32'(timeoutCnt), 32'd0);
    resetCore = 1'b1;
    tick();

    // Write 0x12 <= 0xBEEF, ack at cycle 5
    issue(1'b0, 8'h12, 16'hBEEF, 1'b1, {1'b0, 16'h0000});
    repeat (4) tick();
    chk("wr_req_held", 32'(cpuMemReq), 32'd1);
    chk("wr_rdy_low", 32'(hostReqRdy), 32'd0);
    ack_now();
    chk("wr_rsp_c6", 32'(hostRspVld), 32'd1);
    chk("wr_req_low_c6", 32'(cpuMemReq), 32'd0);
    tick();
    chk("wr_rsp_pulse", 32'(hostRspVld), 32'd0);
    chk("gap_rdy_c7", 32'(hostReqRdy), 32'd0);
    tick();
    chk("idle_rdy_c8", 32'(hostReqRdy), 32'd1);

    // Read 0x12, ack at cycle 6 returns 0xBEEF
    issue(1'b1, 8'h12, 16'h0, 1'b1, {1'b0, 16'hBEEF});
    repeat (5) tick();
    ack_now();
    chk("rd_rsp_c7", 32'(hostRspVld), 32'd1);
    wait_idle(5);

    // Ack while idle is ignored
    ack_now();
    chk("idle_ack_rdy", 32'(hostReqRdy), 32'd1);
    chk("idle_ack_req", 32'(cpuMemReq), 32'd0);

    // Write 0x34, then read it while the controller stalls ten extra cycles
    issue(1'b0, 8'h34, 16'h1234, 1'b1, {1'b0, 16'h0000});
    repeat (2) tick();
    ack_now();
    wait_idle(5);
    issue(1'b1, 8'h34, 16'h0, 1'b1, {1'b0, 16'h1234});
    begin
      int bad = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (!cpuMemReq || cpuMemAddr !== 8'h34 || !cpuMemRd) bad++;
      end
      chk("busy_req_stable", 32'(bad), 32'd0);
    end
    ack_now();
    chk("busy_rsp_c17", 32'(hostRspVld), 32'd1);
    wait_idle(5);

    // No ack: timeout response at cycle 65, DRAIN through 128, IDLE at 131
    issue(1'b1, 8'h56, 16'h0, 1'b1, {1'b1, 16'hFFFF});
    repeat (63) tick();
    chk("to_no_rsp_c64", 32'(hostRspVld), 32'd0);
    chk("to_req_c64", 32'(cpuMemReq), 32'd1);
    tick();
    chk("to_rsp_c65", 32'(hostRspVld), 32'd1);
    chk("to_req_low", 32'(cpuMemReq), 32'd0);
    chk("to_cnt1", 32'(timeoutCnt), 32'd1);
    repeat (63) tick();
    chk("drain_rdy_c128", 32'(hostReqRdy), 32'd0);
    chk("drain_addr_held", 32'(cpuMemAddr), 32'h56);
    chk("drain_req_low", 32'(cpuMemReq), 32'd0);
    repeat (2) tick();
    chk("gap_rdy_c130", 32'(hostReqRdy), 32'd0);
    tick();
    chk("idle_rdy_c131", 32'(hostReqRdy), 32'd1);

    // Timeout, then a late ack three cycles into DRAIN is swallowed
    issue(1'b0, 8'h78, 16'h5A5A, 1'b1, {1'b1, 16'hFFFF});
    repeat (64) tick();
    chk("to2_cnt", 32'(timeoutCnt), 32'd2);
    repeat (3) tick();
    ack_now();
    chk("late_gap_rdy", 32'(hostReqRdy), 32'd0);
    tick();
    chk("late_gap2_rdy", 32'(hostReqRdy), 32'd0);
    tick();
    chk("late_idle_rdy", 32'(hostReqRdy), 32'd1);
    issue(1'b1, 8'h12, 16'h0, 1'b1, {1'b0, 16'hBEEF});
    repeat (2) tick();
    ack_now();
    wait_idle(5);

    // Ack in the same cycle the timer hits TIMEOUT-1: normal completion
    issue(1'b1, 8'h34, 16'h0, 1'b1, {1'b0, 16'h1234});
    repeat (63) tick();
    ack_now();
    chk("race_rsp", 32'(hostRspVld), 32'd1);
    chk("race_cnt", 32'(timeoutCnt), 32'd2);
    wait_idle(5);

    // Reset in REQ: no response, back to idle values
    issue(1'b0, 8'h9A, 16'h7777, 1'b0, '0);
    repeat (2) tick();
    resetCore = 1'b0;
    #1;
    chk("rst_mid_req", 32'(cpuMemReq), 32'd0);
    chk("rst_mid_rdy", 32'(hostReqRdy), 32'd1);
    tick();
    resetCore = 1'b1;
    repeat (3) tick();
    chk("post_rst_req", 32'(cpuMemReq), 32'd0);
    chk("post_rst_rdy", 32'(hostReqRdy), 32'd1);
    chk("post_rst_cnt", 32'(timeoutCnt), 32'd0);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout: observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

endmodule
